// File: rtl/discrete_filter_scheduler.sv
// Time-multiplexes one shared RC low-pass filter core across CHANNELS voices.
// Each sample tick runs one core transaction per enabled channel, then publishes all outputs.
module discrete_filter_scheduler #(
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned WIDTH    = 16,
  localparam int unsigned SelW    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      audio_clk_en,
  input  logic [CHANNELS-1:0]       ch_enable,
  input  logic [CHANNELS*WIDTH-1:0] ch_in,
  output logic [CHANNELS*WIDTH-1:0] ch_out,
  output logic                      frame_done,
  output logic                      overrun,
  output logic                      core_valid,
  output logic [SelW-1:0]           core_sel,
  output logic [WIDTH-1:0]          core_sample,
  output logic [WIDTH-1:0]          core_state,
  input  logic                      core_ready,
  input  logic [WIDTH-1:0]          core_result
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StIssue = 2'd1;
  localparam logic [1:0] StWb    = 2'd2;
  localparam logic [1:0] StSkip  = 2'd3;

  localparam logic [SelW-1:0] LastIdx = SelW'(CHANNELS - 1);

  logic [1:0]          state_q, state_d;
  logic [SelW-1:0]     idx_q, idx_d;
  logic [CHANNELS-1:0] en_q, en_d;
  logic [WIDTH-1:0]    snap_q [CHANNELS];
  logic [WIDTH-1:0]    snap_d [CHANNELS];
  logic [WIDTH-1:0]    bank_q [CHANNELS];
  logic [WIDTH-1:0]    bank_d [CHANNELS];
  logic [WIDTH-1:0]    out_q  [CHANNELS];
  logic [WIDTH-1:0]    out_d  [CHANNELS];
  logic                done_q, done_d;
  logic                ovr_q, ovr_d;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    en_d    = en_q;
    snap_d  = snap_q;
    bank_d  = bank_q;
    out_d   = out_q;
    done_d  = 1'b0;
    ovr_d   = audio_clk_en && (state_q != StIdle);

    case (state_q)
      StIdle: begin
        if (audio_clk_en) begin
          for (int unsigned k = 0; k < CHANNELS; k++) begin
            snap_d[k] = ch_in[k*WIDTH +: WIDTH];
          end
          en_d    = ch_enable;
          idx_d   = '0;
          state_d = ch_enable[0] ? StIssue : StSkip;
        end
      end
      StIssue: begin
        if (core_ready) begin
          bank_d[idx_q] = core_result;
          state_d       = StWb;
        end
      end
      StWb, StSkip: begin
        // Disabled channels lose their filter history.
        if (state_q == StSkip) begin
          bank_d[idx_q] = '0;
        end
        if (idx_q == LastIdx) begin
          state_d = StIdle;
          done_d  = 1'b1;
          out_d   = bank_d;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = en_q[idx_d] ? StIssue : StSkip;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      idx_q   <= '0;
      en_q    <= '0;
      done_q  <= 1'b0;
      ovr_q   <= 1'b0;
      for (int unsigned k = 0; k < CHANNELS; k++) begin
        snap_q[k] <= '0;
        bank_q[k] <= '0;
        out_q[k]  <= '0;
      end
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      en_q    <= en_d;
      done_q  <= done_d;
      ovr_q   <= ovr_d;
      for (int unsigned k = 0; k < CHANNELS; k++) begin
        snap_q[k] <= snap_d[k];
        bank_q[k] <= bank_d[k];
        out_q[k]  <= out_d[k];
      end
    end
  end

  // Request fields come straight from registers and are zeroed outside ISSUE.
  assign core_valid  = (state_q == StIssue);
  assign core_sel    = core_valid ? idx_q : '0;
  assign core_sample = core_valid ? snap_q[idx_q] : '0;
  assign core_state  = core_valid ? bank_q[idx_q] : '0;
  assign frame_done  = done_q;
  assign overrun     = ovr_q;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_out
    assign ch_out[g*WIDTH +: WIDTH] = out_q[g];
  end

endmodule

// File: tb/tb_discrete_filter_scheduler.sv
// Bench for discrete_filter_scheduler: directed test-plan frames followed by random ticks,
// resets, enables and core stalls, checked cycle by cycle against a frame-level model.
module tb_discrete_filter_scheduler;

  localparam int CH = 4;
  localparam int W  = 16;

  logic            clk = 1'b0;
  logic            reset;
  logic            audio_clk_en;
  logic [CH-1:0]   ch_enable;
  logic [CH*W-1:0] ch_in;
  logic [CH*W-1:0] ch_out;
  logic            frame_done;
  logic            overrun;
  logic            core_valid;
  logic [1:0]      core_sel;
  logic [W-1:0]    core_sample;
  logic [W-1:0]    core_state;
  logic            core_ready;
  logic [W-1:0]    core_result;

  always #5 clk = ~clk;

  discrete_filter_scheduler #(.CHANNELS(CH), .WIDTH(W)) dut (
    .clk          (clk),
    .reset        (reset),
    .audio_clk_en (audio_clk_en),
    .ch_enable    (ch_enable),
    .ch_in        (ch_in),
    .ch_out       (ch_out),
    .frame_done   (frame_done),
    .overrun      (overrun),
    .core_valid   (core_valid),
    .core_sel     (core_sel),
    .core_sample  (core_sample),
    .core_state   (core_state),
    .core_ready   (core_ready),
    .core_result  (core_result)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  // Frame-level reference model.
  bit           active  = 1'b0;
  bit           ov_next = 1'b0;
  int           t0      = 0;
  int           done_cyc = 0;
  logic [W-1:0] m_bank [CH];
  logic [W-1:0] m_out  [CH];
  logic [W-1:0] m_snap [CH];
  logic [CH-1:0] m_en;
  int           m_wait [CH];
  bit           ev [64];
  int           es [64];
  int           wcnt = 0;

  bit           use_dir  = 1'b0;
  logic [CH-1:0] dir_en;
  logic [W-1:0] dir_in [CH];
  int           dir_wait = -1;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Schedule: ISSUE lasts wait+1 cycles then one WB; a skipped channel takes one cycle.
  task automatic plan_frame();
    int c;
    t0   = cyc;
    m_en = ch_enable;
    for (int k = 0; k < CH; k++) begin
      m_snap[k] = ch_in[k*W +: W];
      m_wait[k] = (dir_wait >= 0) ? dir_wait : int'($urandom_range(0, 3));
    end
    for (int i = 0; i < 64; i++) begin
      ev[i] = 1'b0;
      es[i] = 0;
    end
    c = 1;
    for (int k = 0; k < CH; k++) begin
      if (m_en[k]) begin
        for (int w = 0; w <= m_wait[k]; w++) begin
          ev[c+w] = 1'b1;
          es[c+w] = k;
        end
        c += m_wait[k] + 2;
      end else begin
        c += 1;
      end
    end
    done_cyc = t0 + c;
    active   = 1'b1;
  endtask

  task automatic do_cycle(input bit tk, input bit rs);
    int            off;
    int            k;
    bit            exp_v;
    bit            exp_done;
    logic [CH*W-1:0] exp_out;
    @(negedge clk);
    off      = cyc - t0;
    exp_v    = active && (off >= 0) && (off < 64) && ev[off];
    exp_done = active && (cyc == done_cyc);
    if (exp_done) begin
      for (int j = 0; j < CH; j++) begin
        m_bank[j] = m_en[j] ? W'(m_bank[j] + m_snap[j]) : '0;
        m_out[j]  = m_bank[j];
      end
      active = 1'b0;
    end
    check_eq("core_valid", 64'(core_valid), 64'(exp_v));
    if (exp_v) begin
      k = es[off];
      check_eq("core_sel", 64'(core_sel), 64'(k));
      check_eq("core_sample", 64'(core_sample), 64'(m_snap[k]));
      check_eq("core_state", 64'(core_state), 64'(m_bank[k]));
    end
    check_eq("frame_done", 64'(frame_done), 64'(exp_done));
    check_eq("overrun", 64'(overrun), 64'(ov_next));
    ov_next = 1'b0;
    for (int j = 0; j < CH; j++) exp_out[j*W +: W] = m_out[j];
    check_eq("ch_out", 64'(ch_out), 64'(exp_out));

    // Core stub: accept after the planned wait, result = state + sample.
    core_ready  = 1'b0;
    core_result = W'($urandom);
    if (core_valid) begin
      k = exp_v ? es[off] : 0;
      if (wcnt >= m_wait[k]) begin
        core_ready  = 1'b1;
        core_result = W'(core_state + core_sample);
        wcnt        = 0;
      end else begin
        wcnt++;
      end
    end

    reset        = rs;
    audio_clk_en = tk && !rs;
    ch_in        = {$urandom, $urandom};
    ch_enable    = CH'($urandom);
    if (rs) begin
      for (int j = 0; j < CH; j++) begin
        m_bank[j] = '0;
        m_out[j]  = '0;
      end
      active  = 1'b0;
      wcnt    = 0;
    end else if (tk) begin
      if (use_dir) begin
        ch_enable = dir_en;
        for (int j = 0; j < CH; j++) ch_in[j*W +: W] = dir_in[j];
      end
      if (active) ov_next = 1'b1;
      else        plan_frame();
    end
    cyc++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) do_cycle(1'b0, 1'b0);
  endtask

  initial begin
    int r;
    reset        = 1'b1;
    audio_clk_en = 1'b0;
    ch_enable    = '0;
    ch_in        = '0;
    core_ready   = 1'b0;
    core_result  = '0;
    for (int j = 0; j < CH; j++) begin
      m_bank[j] = '0;
      m_out[j]  = '0;
      m_snap[j] = '0;
      m_wait[j] = 0;
    end
    repeat (3) @(posedge clk);

    // Zero-wait core, all enabled, two frames.
    use_dir  = 1'b1;
    dir_en   = 4'hF;
    dir_in[0] = 16'd100; dir_in[1] = 16'd200; dir_in[2] = 16'd300; dir_in[3] = 16'd400;
    dir_wait = 0;
    run(2);
    do_cycle(1'b1, 1'b0); run(12);
    do_cycle(1'b1, 1'b0); run(12);

    // Stalling core.
    dir_wait = 3;
    do_cycle(1'b1, 1'b0); run(25);

    // Enable mask 0101, two frames.
    dir_wait = 0;
    dir_en   = 4'b0101;
    do_cycle(1'b1, 1'b0); run(10);
    do_cycle(1'b1, 1'b0); run(10);

    // Overrun tick in cycle 4.
    dir_en = 4'hF;
    do_cycle(1'b1, 1'b0); run(3);
    do_cycle(1'b1, 1'b0); run(10);

    // Reset in cycle 4 while ISSUE is stalled, then restart.
    dir_wait = 3;
    do_cycle(1'b1, 1'b0); run(3);
    do_cycle(1'b0, 1'b1); run(3);
    do_cycle(1'b1, 1'b0); run(25);

    // Back-to-back tick on the frame_done cycle.
    dir_wait = 0;
    do_cycle(1'b1, 1'b0); run(8);
    do_cycle(1'b1, 1'b0); run(12);

    // Random traffic.
    use_dir  = 1'b0;
    dir_wait = -1;
    for (int i = 0; i < 3000; i++) begin
      r = int'($urandom_range(0, 299));
      do_cycle(r < 45, r == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
